accum_drain: RTL and testbench
==============================

ACCUM_DRAIN -- requirements
Module: accum_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per accumulator element.
REQ-002 Parameter SYS_ARR_COLS, default 16, accumulator columns read in lockstep.
REQ-003 Parameter NUM_ACCUM_ROWS, default 1024, rows per column; AW = $clog2(NUM_ACCUM_ROWS).
REQ-004 Port clk, input, 1, single clock; all logic on rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-high reset.
REQ-006 Port start, input, 1, one-cycle request to begin a drain; sampled only in IDLE.
REQ-007 Port base_addr, input, AW, first row to read; captured with start.
REQ-008 Port num_rows, input, AW+1, rows to drain (0..NUM_ACCUM_ROWS); captured with start.
REQ-009 Port busy, output, 1, high in every state except IDLE.
REQ-010 Port done, output, 1, one-cycle pulse when drain fully finished.
REQ-011 Port acc_rd_en, output, SYS_ARR_COLS, read enable per column; all bits always equal.
REQ-012 Port acc_rd_addr, output, AW*SYS_ARR_COLS, read address, same value replicated in every AW slice.
REQ-013 Port acc_rd_data, input, DATA_WIDTH*SYS_ARR_COLS, read data, valid exactly one cycle after acc_rd_en.
REQ-014 Port acc_clear, output, SYS_ARR_COLS, column clear strobe; all bits always equal.
REQ-015 Port out_valid, output, 1; out_ready, input, 1; valid/ready stream handshake.
REQ-016 Port out_data, output, DATA_WIDTH*SYS_ARR_COLS, one full accumulator row.
REQ-017 Port out_row, output, AW, accumulator address of row on out_data.

Function
REQ-018 FSM states IDLE, ISSUE, FLUSH, CLEAR, DONE; IDLE->ISSUE on start (num_rows>0), IDLE->DONE on start with num_rows==0.
REQ-019 ISSUE: one read per cycle when credit allows; row i address = (base_addr+i) mod NUM_ACCUM_ROWS (wrap-around).
REQ-020 Credit: read issued only if (reads in flight + buffered rows) < 2; buffer is a 2-entry FIFO capturing acc_rd_data and its address.
REQ-021 Transfer occurs when out_valid && out_ready; out_valid = FIFO non-empty; out_data/out_row held stable while out_valid && !out_ready.
REQ-022 Rows emitted in issue order, none dropped or duplicated; with out_ready held high, throughput is one row per cycle, first out_valid 2 cycles after start.
REQ-023 ISSUE->FLUSH after num_rows reads issued; FLUSH->CLEAR (or DONE, see REQ-029) when nothing in flight and FIFO empty.
REQ-024 CLEAR: acc_clear all-ones for exactly one cycle, then DONE; DONE asserts done one cycle, then IDLE.
REQ-025 start while busy is ignored; simultaneous FIFO push and pop in one cycle is legal and keeps occupancy.
REQ-026 acc_rd_en never asserted outside ISSUE; acc_rd_addr value irrelevant when acc_rd_en low.

Reset
REQ-027 reset asynchronously forces IDLE, FIFO empty, in-flight count 0; busy, done, out_valid, acc_rd_en, acc_clear all 0; out_data, out_row, acc_rd_addr 0.
REQ-028 reset mid-drain abandons the drain: no done pulse, no acc_clear pulse, read data returning after reset is discarded.

Configuration
REQ-029 Macro ACCUM_DRAIN_CLEAR_EN defined: CLEAR state present, acc_clear pulses per REQ-024 (including num_rows==0 path); undefined: FLUSH->DONE directly and acc_clear tied to 0.

Structure
REQ-030 Shared package holds drain FSM state enum and the FIFO depth constant (2).
REQ-031 The 2-entry FIFO is a sub-module named accum_drain_fifo; the FSM, counters and credit logic stay in accum_drain.

Verification
REQ-032 start, base_addr=5, num_rows=4, out_ready=1 -> reads at 5,6,7,8 on consecutive cycles, out_row 5..8 on consecutive cycles, done once, busy low after.
REQ-033 base_addr=NUM_ACCUM_ROWS-2, num_rows=4 -> addresses N-2, N-1, 0, 1.
REQ-034 num_rows=8, out_ready toggling 1/0 each cycle -> 8 rows in order, data unchanged while stalled, never >2 buffered, no read while credit exhausted.
REQ-035 num_rows=0 -> no acc_rd_en, done within 3 cycles; acc_clear pulse only with ACCUM_DRAIN_CLEAR_EN.
REQ-036 reset asserted after 3 of 6 rows -> all outputs 0 immediately, no done/acc_clear; new start afterward drains correctly.
REQ-037 start pulsed again during drain -> ignored, row count and done count unchanged.

Source files
------------

// File: rtl/accum_drain_pkg.sv
// accum_drain_pkg: shared types and constants for the accumulator drain block.
//   drain_state_e : drain FSM state encoding
//   FIFO_DEPTH    : depth of the output row buffer (also the read credit limit)
package accum_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FLUSH,
    ST_CLEAR,
    ST_DONE
  } drain_state_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/accum_drain_if.sv
// accum_drain_if: output row stream of the accumulator drain.
//   out_valid/out_ready : valid/ready handshake, transfer when both high
//   out_data            : one full accumulator row (all columns)
//   out_row             : accumulator address of the row on out_data
// master = drain block, slave = row consumer.
interface accum_drain_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int SYS_ARR_COLS = 16,
  parameter int AW           = 10
);
  logic                               out_valid;
  logic                               out_ready;
  logic [DATA_WIDTH*SYS_ARR_COLS-1:0] out_data;
  logic [AW-1:0]                      out_row;

  modport master (output out_valid, out_data, out_row, input out_ready);
  modport slave  (input out_valid, out_data, out_row, output out_ready);
endinterface

// File: rtl/accum_drain_fifo.sv
// accum_drain_fifo: FIFO_DEPTH-entry buffer holding returned accumulator rows
// together with their row address.
//   clk, reset          : clock, async active-high reset (clears storage too)
//   push, push_data/row : write one entry (caller guarantees not full)
//   pop                 : drop head entry (caller guarantees not empty)
//   head_data/head_row  : current head entry, stable until popped
//   empty, count        : occupancy
// Simultaneous push and pop keeps occupancy unchanged.
module accum_drain_fifo
  import accum_drain_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 10,
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [AW-1:0] push_row,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [AW-1:0] head_row,
  output logic          empty,
  output logic [PW:0]   count
);

  logic [DW-1:0] data_mem [FIFO_DEPTH];
  logic [AW-1:0] row_mem  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        row_mem[i]  <= '0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= push_data;
        row_mem[wr_ptr]  <= push_row;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign head_data = data_mem[rd_ptr];
  assign head_row  = row_mem[rd_ptr];
  assign empty     = (count == '0);

endmodule

// File: rtl/accum_drain.sv
// accum_drain: reads NUM_ROWS accumulator rows starting at base_addr (wrapping
// modulo NUM_ACCUM_ROWS) and streams them out over a valid/ready interface.
//   clk, reset          : clock, async active-high reset
//   start               : begin a drain (sampled in IDLE only)
//   base_addr, num_rows : drain window, captured with start
//   busy, done          : not-IDLE flag, one-cycle completion pulse
//   acc_rd_en/addr/data : accumulator read port (data one cycle after en)
//   acc_clear           : one-cycle column clear after the drain
//   out_if (master)     : out_valid/out_ready/out_data/out_row row stream
// Build option: define ACCUM_DRAIN_CLEAR_EN to add the CLEAR state and the
// acc_clear pulse; otherwise FLUSH goes straight to DONE and acc_clear is 0.
module accum_drain
  import accum_drain_pkg::*;
#(
  parameter int  DATA_WIDTH     = 8,
  parameter int  SYS_ARR_COLS   = 16,
  parameter int  NUM_ACCUM_ROWS = 1024,
  localparam int AW             = $clog2(NUM_ACCUM_ROWS),
  localparam int RW             = DATA_WIDTH * SYS_ARR_COLS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [AW-1:0]              base_addr,
  input  logic [AW:0]                num_rows,
  output logic                       busy,
  output logic                       done,
  output logic [SYS_ARR_COLS-1:0]    acc_rd_en,
  output logic [AW*SYS_ARR_COLS-1:0] acc_rd_addr,
  input  logic [RW-1:0]              acc_rd_data,
  output logic [SYS_ARR_COLS-1:0]    acc_clear,
  accum_drain_if.master              out_if
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  drain_state_e state_q, state_d;

  logic [AW-1:0] addr_q;    // next row address to read
  logic [AW:0]   rem_q;     // reads still to issue
  logic          rd_vld;    // read issued last cycle, data on acc_rd_data now
  logic [AW-1:0] rd_row_q;  // address of that in-flight read
  logic          issue, pop, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [2:0]    pend;
  logic [SYS_ARR_COLS-1:0][AW-1:0] rd_addr_lanes;

  assign pop = out_if.out_valid && out_if.out_ready;

  // Rows that will occupy the buffer after this cycle: current entries plus
  // the row landing now, minus the one leaving. Counting the pop lets a read
  // go out every cycle while the consumer keeps up.
  assign pend  = 3'(rd_vld) + 3'(fifo_cnt) - 3'(pop);
  assign issue = (state_q == ST_ISSUE) && (pend < 3'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_rows != '0) state_d = ST_ISSUE;
`ifdef ACCUM_DRAIN_CLEAR_EN
          else                state_d = ST_CLEAR;
`else
          else                state_d = ST_DONE;
`endif
        end
      end
      ST_ISSUE: if (issue && rem_q == (AW+1)'(1)) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (!rd_vld && fifo_empty) begin
`ifdef ACCUM_DRAIN_CLEAR_EN
          state_d = ST_CLEAR;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef ACCUM_DRAIN_CLEAR_EN
      ST_CLEAR: state_d = ST_DONE;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      rem_q    <= '0;
      rd_vld   <= 1'b0;
      rd_row_q <= '0;
    end else begin
      rd_vld <= issue;
      if (state_q == ST_IDLE && start) begin
        addr_q <= base_addr;
        rem_q  <= num_rows;
      end else if (issue) begin
        addr_q   <= (addr_q == AW'(NUM_ACCUM_ROWS - 1)) ? '0 : addr_q + 1'b1;
        rem_q    <= rem_q - 1'b1;
        rd_row_q <= addr_q;
      end
    end
  end

  accum_drain_fifo #(.DW(RW), .AW(AW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_vld),
    .push_data (acc_rd_data),
    .push_row  (rd_row_q),
    .pop       (pop),
    .head_data (out_if.out_data),
    .head_row  (out_if.out_row),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign out_if.out_valid = !fifo_empty;
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);

  for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_lane
    assign acc_rd_en[c]     = issue;
    assign rd_addr_lanes[c] = addr_q;
`ifdef ACCUM_DRAIN_CLEAR_EN
    assign acc_clear[c]     = (state_q == ST_CLEAR);
`else
    assign acc_clear[c]     = 1'b0;
`endif
  end
  assign acc_rd_addr = rd_addr_lanes;

endmodule

// File: tb/tb_accum_drain.sv
// tb_accum_drain: randomized self-checking bench for accum_drain. A row memory
// answers reads one cycle later; the expected row stream is the list
// (base+i) mod ROWS with that memory's contents. Honors ACCUM_DRAIN_CLEAR_EN.
module tb_accum_drain;
  localparam int DW   = 8;
  localparam int COLS = 4;
  localparam int ROWS = 16;
  localparam int AW   = $clog2(ROWS);
  localparam int RW   = DW * COLS;
`ifdef ACCUM_DRAIN_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_rows = '0;
  logic busy, done;
  logic [COLS-1:0] acc_rd_en, acc_clear;
  logic [AW*COLS-1:0] acc_rd_addr;
  logic [RW-1:0] acc_rd_data = '0;

  accum_drain_if #(.DATA_WIDTH(DW), .SYS_ARR_COLS(COLS), .AW(AW)) out_if ();

  accum_drain #(.DATA_WIDTH(DW), .SYS_ARR_COLS(COLS), .NUM_ACCUM_ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .busy(busy), .done(done), .acc_rd_en(acc_rd_en),
    .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
    .acc_clear(acc_clear), .out_if(out_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference state
  logic [RW-1:0] mem [ROWS];
  int rd_q[$], row_q[$];
  logic [RW-1:0] data_q[$];
  int cyc = 0, outst = 0, done_cnt = 0, clr_cnt = 0, done_cyc = 0;
  int first_rd = -1, last_rd = -1, n_rd = 0, first_x = -1, last_x = -1, n_x = 0;
  int ready_mode = 0;
  logic prev_stall = 1'b0;
  logic [RW-1:0] prev_data = '0;
  logic [AW-1:0] prev_row = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // accumulator memory: data one cycle after the read, garbage otherwise
  always @(posedge clk)
    acc_rd_data <= acc_rd_en[0] ? mem[acc_rd_addr[AW-1:0]] : RW'($urandom);

  initial out_if.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_if.out_ready = 1'b1;
      1:       out_if.out_ready = ~out_if.out_ready;
      default: out_if.out_ready = 1'($urandom);
    endcase
  end

  always @(negedge clk) if (!reset) begin
    logic xfer;
    xfer = out_if.out_valid && out_if.out_ready;
    chk("rd_en_lanes", acc_rd_en, {COLS{acc_rd_en[0]}});
    chk("clear_lanes", acc_clear, {COLS{acc_clear[0]}});
    if (acc_rd_en[0]) begin
      chk("rd_addr_lanes", acc_rd_addr, {COLS{acc_rd_addr[AW-1:0]}});
      chk("rd_while_busy", busy, 1);
      chk("read_expected", rd_q.size() != 0, 1);
      if (rd_q.size() != 0) chk("rd_addr", acc_rd_addr[AW-1:0], rd_q.pop_front());
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      n_rd++;
    end
    if (prev_stall) begin
      chk("stall_valid", out_if.out_valid, 1);
      chk("stall_data", out_if.out_data, prev_data);
      chk("stall_row", out_if.out_row, prev_row);
    end
    if (xfer) begin
      chk("row_expected", row_q.size() != 0, 1);
      if (row_q.size() != 0) begin
        chk("out_row", out_if.out_row, row_q.pop_front());
        chk("out_data", out_if.out_data, data_q.pop_front());
      end
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
      n_x++;
    end
    outst = outst + int'(acc_rd_en[0]) - int'(xfer);
    chk("outstanding_le2", outst <= 2, 1);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (acc_clear[0]) clr_cnt++;
    prev_stall = out_if.out_valid && !out_if.out_ready;
    prev_data  = out_if.out_data;
    prev_row   = out_if.out_row;
  end

  // load fresh memory, build expected streams, pulse start; s = first busy cycle
  task automatic kick(input int base, input int n, output int s);
    for (int i = 0; i < ROWS; i++) mem[i] = RW'($urandom);
    for (int i = 0; i < n; i++) begin
      rd_q.push_back((base + i) % ROWS);
      row_q.push_back((base + i) % ROWS);
      data_q.push_back(mem[(base + i) % ROWS]);
    end
    done_cnt = 0; clr_cnt = 0; n_rd = 0; n_x = 0;
    first_rd = -1; last_rd = -1; first_x = -1; last_x = -1;
    @(negedge clk);
    base_addr = AW'(base); num_rows = (AW+1)'(n); start = 1'b1;
    @(negedge clk);
    s = cyc;
    start = 1'b0; base_addr = AW'($urandom); num_rows = (AW+1)'($urandom);
  endtask

  task automatic run_drain(input int base, input int n, input int mode,
                           input bit restart, input bit timing);
    int s;
    ready_mode = mode;
    kick(base, n, s);
    if (restart) begin
      @(negedge clk);
      start = 1'b1; base_addr = AW'(3); num_rows = (AW+1)'(5);
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 300 && !(done_cnt > 0 && !busy); k++) @(negedge clk);
    chk("drain_finished", done_cnt > 0 && !busy, 1);
    repeat (3) @(negedge clk);
    chk("rows_left", row_q.size(), 0);
    chk("reads_left", rd_q.size(), 0);
    chk("rows_seen", n_x, n);
    chk("reads_seen", n_rd, n);
    chk("done_count", done_cnt, 1);
    chk("clear_count", clr_cnt, CLR);
    chk("busy_after", busy, 0);
    chk("valid_after", out_if.out_valid, 0);
    if (timing && n > 0) begin
      chk("first_read_cyc", first_rd, s);
      chk("read_span", last_rd - first_rd, n - 1);
      chk("first_out_cyc", first_x, s + 2);
      chk("out_span", last_x - first_x, n - 1);
    end
    if (n == 0) chk("zero_done_latency", (done_cyc - s) <= 3, 1);
    rd_q.delete(); row_q.delete(); data_q.delete();
  endtask

  initial begin
    int s;
    for (int i = 0; i < ROWS; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_flags", {busy, done, out_if.out_valid, |acc_rd_en, |acc_clear}, 0);
    chk("rst_data", out_if.out_data, 0);
    chk("rst_row", out_if.out_row, 0);
    chk("rst_addr", acc_rd_addr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_drain(5, 4, 0, 0, 1);
    run_drain(ROWS - 2, 4, 0, 0, 1);
    run_drain($urandom_range(0, ROWS - 1), 8, 1, 0, 0);
    run_drain($urandom_range(0, ROWS - 1), 0, 0, 0, 0);

    // reset in the middle of a 6-row drain
    ready_mode = 0;
    kick(9, 6, s);
    for (int k = 0; k < 100 && n_x < 3; k++) @(negedge clk);
    chk("midreset_progress", n_x >= 3, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_flags", {busy, done, out_if.out_valid, |acc_rd_en, |acc_clear}, 0);
    chk("midrst_data", out_if.out_data, 0);
    chk("midrst_row", out_if.out_row, 0);
    chk("midrst_addr", acc_rd_addr, 0);
    rd_q.delete(); row_q.delete(); data_q.delete();
    outst = 0; prev_stall = 1'b0; done_cnt = 0; clr_cnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_clear", clr_cnt, 0);
    chk("midrst_idle", {busy, out_if.out_valid}, 0);
    run_drain(9, 6, 0, 0, 1);

    run_drain(2, 6, 0, 1, 1);
    run_drain(7, ROWS, 2, 0, 0);
    for (int t = 0; t < 4; t++)
      run_drain($urandom_range(0, ROWS - 1), $urandom_range(1, ROWS), 2, t[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
